// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one column at a time, synchronises
// the row returns into the clk_raw domain, debounces whole-keypad snapshots
// and encodes the accepted state into the 12-bit keystroke vector used by
// core.
//
// Ports:
//   clk_raw    in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   row_n      in   4   row returns, active-low, asynchronous to clk_raw
//   col_n      out  4   column drive, active-low, at most one bit low
//   keystroke  out 12   [3:0] column one-hot, [7:4] row one-hot,
//                       [8] pressed, [9] long-press, [10] multi-key,
//                       [11] auto-repeat pulse
//   key_event  out  1   one-cycle pulse when keystroke[10:0] changes
//                       (and on every auto-repeat pulse)
//
// Build option:
//   KEYPAD_REPEAT_EN  when defined, builds the auto-repeat counter that
//                     drives keystroke[11]; otherwise keystroke[11] is 0.
//
// Snapshot layout: bit 4*c + r is row r seen while column c was driven.
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_CYC       = 4096,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int HOLD_SCANS     = 256,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic        clk_raw,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [11:0] keystroke,
  output logic        key_event
);

  localparam int CYC_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int HLD_W = (HOLD_SCANS > 0) ? $clog2(HOLD_SCANS + 1) : 1;

  localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SCAN_CYC - 1);
  localparam logic [STB_W-1:0] STB_ZERO = {STB_W{1'b0}};
  localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [HLD_W-1:0] HLD_ZERO = {HLD_W{1'b0}};
  localparam logic [HLD_W-1:0] HLD_ONE  = HLD_W'(1);
  localparam logic [HLD_W-1:0] HLD_MAX  = HLD_W'(HOLD_SCANS);

  // S_IDLE only exists while reset is held; the first edge afterwards
  // starts DRIVE0.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE0 = 3'd1,
    S_DRIVE1 = 3'd2,
    S_DRIVE2 = 3'd3,
    S_DRIVE3 = 3'd4
  } scan_state_e;

  scan_state_e      state_q, state_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [1:0]       col_idx_s;
  logic             col_last_s;
  logic             pass_end_s;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [3:0]       rows_s;

  logic [15:0]      snap_q, snap_full_s, prev_snap_q, acc_snap_q;
  logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
  logic             acc_valid_q;

  logic [4:0]       key_cnt_s;
  logic [3:0]       key_idx_s;
  logic [8:0]       single_code_s;
  logic             same_key_s;
  logic [HLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [11:0]      keystroke_q, keystroke_d;
  logic             key_event_q, key_event_d;
  logic             rep_pulse_s;

  // Number of closed contacts in a snapshot.
  function automatic logic [4:0] key_count(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Position of the lowest closed contact (only meaningful for one key).
  function automatic logic [3:0] key_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // Two-flop row synchroniser; resets to the idle (no key) level.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  assign rows_s = ~row_sync_q;

  // Scan FSM state and dwell counter registers.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_cnt_q <= CYC_ZERO;
      col_n_q   <= 4'b1111;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      col_n_q   <= col_n_d;
    end
  end

  assign col_last_s = (state_q != S_IDLE) && (cyc_cnt_q == CYC_LAST);
  assign pass_end_s = col_last_s && (state_q == S_DRIVE3);

  // Scan FSM next state: each column dwells SCAN_CYC cycles, 3 wraps to 0.
  always_comb begin
    state_d   = state_q;
    col_idx_s = 2'd0;
    case (state_q)
      S_IDLE: begin
        state_d = S_DRIVE0;
      end
      S_DRIVE0: begin
        col_idx_s = 2'd0;
        if (col_last_s) state_d = S_DRIVE1;
        else            state_d = S_DRIVE0;
      end
      S_DRIVE1: begin
        col_idx_s = 2'd1;
        if (col_last_s) state_d = S_DRIVE2;
        else            state_d = S_DRIVE1;
      end
      S_DRIVE2: begin
        col_idx_s = 2'd2;
        if (col_last_s) state_d = S_DRIVE3;
        else            state_d = S_DRIVE2;
      end
      S_DRIVE3: begin
        col_idx_s = 2'd3;
        if (col_last_s) state_d = S_DRIVE0;
        else            state_d = S_DRIVE3;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_q == S_IDLE || col_last_s) begin
      cyc_cnt_d = CYC_ZERO;
    end else begin
      cyc_cnt_d = cyc_cnt_q + CYC_ONE;
    end
  end

  // Column drive decoded from the next state so col_n is a plain register.
  always_comb begin
    col_n_d = 4'b1111;
    case (state_d)
      S_DRIVE0: col_n_d = 4'b1110;
      S_DRIVE1: col_n_d = 4'b1101;
      S_DRIVE2: col_n_d = 4'b1011;
      S_DRIVE3: col_n_d = 4'b0111;
      default:  col_n_d = 4'b1111;
    endcase
  end

  // Capture the synchronised rows on the last cycle of each column.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= 16'h0000;
    end else if (col_last_s) begin
      snap_q[{col_idx_s, 2'b00} +: 4] <= rows_s;
    end else begin
      snap_q <= snap_q;
    end
  end

  // Column 3 rows are sampled in the pass-end cycle itself, so merge them in.
  assign snap_full_s = {rows_s, snap_q[11:0]};

  // Consecutive-identical-pass counter, saturating at DEBOUNCE_SCANS.
  always_comb begin
    if (snap_full_s == prev_snap_q) begin
      if (stable_cnt_q == STB_MAX) stable_cnt_d = STB_MAX;
      else                         stable_cnt_d = stable_cnt_q + STB_ONE;
    end else begin
      stable_cnt_d = STB_ONE;
    end
  end

  // Pass-end bookkeeping; acc_valid_q marks an accepted pass for one cycle.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      prev_snap_q  <= 16'h0000;
      stable_cnt_q <= STB_ZERO;
      acc_valid_q  <= 1'b0;
      acc_snap_q   <= 16'h0000;
    end else if (pass_end_s) begin
      prev_snap_q  <= snap_full_s;
      stable_cnt_q <= stable_cnt_d;
      acc_valid_q  <= (stable_cnt_d == STB_MAX);
      acc_snap_q   <= snap_full_s;
    end else begin
      acc_valid_q  <= 1'b0;
    end
  end

  assign key_cnt_s     = key_count(acc_snap_q);
  assign key_idx_s     = key_index(acc_snap_q);
  // {pressed, row one-hot, column one-hot}; idx = 4*column + row.
  assign single_code_s = {1'b1, 4'b0001 << key_idx_s[1:0], 4'b0001 << key_idx_s[3:2]};
  // Same single key as currently reported.
  assign same_key_s    = keystroke_q[8] && !keystroke_q[10] &&
                         (keystroke_q[7:0] == single_code_s[7:0]);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // Repeat counter only runs once long-press is already reported.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_pulse_s = 1'b0;
    if (acc_valid_q) begin
      if ((key_cnt_s == 5'd1) && same_key_s && keystroke_q[9]) begin
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d   = REP_ZERO;
          rep_pulse_s = 1'b1;
        end else begin
          rep_cnt_d   = rep_cnt_q + REP_ONE;
        end
      end else begin
        rep_cnt_d = REP_ZERO;
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= REP_ZERO;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  logic unused_repeat_s;
  assign unused_repeat_s = (REPEAT_SCANS > 0);
  assign rep_pulse_s     = 1'b0;
`endif

  // Encode an accepted snapshot; between accepted passes the code holds.
  always_comb begin
    keystroke_d = {1'b0, keystroke_q[10:0]};
    key_event_d = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    if (acc_valid_q) begin
      if (key_cnt_s == 5'd0) begin
        keystroke_d[10:0] = 11'h000;
        hold_cnt_d        = HLD_ZERO;
      end else if (key_cnt_s == 5'd1) begin
        if (same_key_s) begin
          if (hold_cnt_q == HLD_MAX) hold_cnt_d = HLD_MAX;
          else                       hold_cnt_d = hold_cnt_q + HLD_ONE;
        end else begin
          hold_cnt_d = HLD_ZERO;
        end
        keystroke_d[10:0] = {1'b0, (hold_cnt_d == HLD_MAX), single_code_s};
      end else begin
        keystroke_d[10:0] = 11'h500;
        hold_cnt_d        = HLD_ZERO;
      end
      keystroke_d[11] = rep_pulse_s;
      key_event_d     = (keystroke_d[10:0] != keystroke_q[10:0]) || rep_pulse_s;
    end else begin
      keystroke_d[11] = 1'b0;
      key_event_d     = 1'b0;
    end
  end

  // Output and hold-counter registers.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      keystroke_q <= 12'h000;
      key_event_q <= 1'b0;
      hold_cnt_q  <= HLD_ZERO;
    end else begin
      keystroke_q <= keystroke_d;
      key_event_q <= key_event_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign col_n     = col_n_q;
  assign keystroke = keystroke_q;
  assign key_event = key_event_q;

endmodule
